return_stack_controller: RTL and testbench
==========================================

Name: return_stack_controller

Overview:
- Return-address stack that serves subroutine call/return (JSB/RET) for the pipelined core.
- Accepts the push_stack / pop_stack strobes from the jump controller and stores return PCs in a LIFO of DEPTH entries.
- Presents the current top of stack as a registered value that is valid in the same cycle RET selects the stack as the PC source.
- Tracks occupancy, honours pipeline stalls, and raises sticky overflow/underflow error flags.

Parameters:
ADDR_WIDTH, 12, width of a stored return PC
DEPTH, 8, number of stack entries (power of two, >=2)
PTR_WIDTH, $clog2(DEPTH)+1, width of the occupancy count (holds 0..DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
push_stack  input  1  push request (JSB), from the jump controller
pop_stack  input  1  pop request (RET), from the jump controller
push_addr  input  ADDR_WIDTH  return PC (PC+1 of the JSB) to store
stall  input  1  pipeline freeze; while high, push/pop are ignored
clear  input  1  synchronous flush of the whole stack and both error flags
top_addr  output  ADDR_WIDTH  registered current top entry; 0 when empty
count  output  PTR_WIDTH  number of valid entries
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: a push was dropped because the stack was full
underflow  output  1  sticky: a pop was issued while the stack was empty

Behaviour:
- Reset (rst low, asynchronous): count=0, top_addr=0, overflow=0, underflow=0, empty=1, full=0. Storage contents don't care. Reset mid-sequence discards all entries immediately.
- Priority each rising edge: clear > stall > push/pop.
- clear=1: count=0, top_addr=0, both flags=0, regardless of stall, push or pop.
- stall=1 (clear=0): all state holds and push/pop are ignored.
- Push only:
  - If not full: mem[count] <= push_addr, count+1, top_addr <= push_addr.
  - If full: state unchanged, overflow <= 1.
- Pop only:
  - If count >= 2: count-1, top_addr <= mem[count-2].
  - If count == 1: count=0, top_addr <= 0.
  - If empty: state unchanged, underflow <= 1.
- Push and pop in the same cycle:
  - Not empty: replace in place. mem[count-1] <= push_addr, top_addr <= push_addr, count unchanged, no flag raised (also when full).
  - Empty: behaves as a plain push, no underflow.
- Timing: top_addr is a register, not a combinational memory read.
  - After a push, the pushed address is visible on the next cycle.
  - A RET issued in cycle N reads top_addr at N, then the stack pops at the N edge.
- Width rules: count saturates at 0 and DEPTH; no wrap-around. Storage index is count-1 or count truncated to $clog2(DEPTH) bits. push_addr is stored unmodified.
- empty and full are combinational decodes of count. Flags clear only on reset or clear.

Test Plan:
- Reset, then push 0x010, 0x020, 0x030 -> count=3, top_addr=0x030; three pops -> top_addr 0x020, 0x010, 0, then empty=1, underflow=0.
- Push 9 addresses 0x100..0x108 with DEPTH=8 -> full=1 after the 8th, overflow=1 after the 9th, top_addr=0x107; 8 pops return 0x107..0x100 in order.
- Pop while empty -> underflow=1, count=0, top_addr=0; a following push of 0x055 -> top_addr=0x055 with underflow still 1; clear -> underflow=0, count=0.
- Push 0x0A0, then assert push+pop together with push_addr=0x0B0 -> count=1, top_addr=0x0B0; a pop then gives empty=1.
- Push 0x011, then hold stall=1 while pulsing push 0x022 and pop -> count=1, top_addr=0x011; release stall and pop -> empty.
- Push 4 entries, drop rst low mid-cycle -> outputs go to 0 and empty=1 immediately without waiting for a clock edge; pushes after reset release work from count=0.

Source files
------------

// File: rtl/return_stack_controller.sv
// Return-address stack for JSB/RET: LIFO of return PCs with a registered top entry,
// occupancy count, stall hold, synchronous flush and sticky overflow/underflow flags.
module return_stack_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_stack,
  input  logic                  pop_stack,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  stall,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic [PTR_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int IDX_WIDTH = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0]  count_nxt;
  logic [ADDR_WIDTH-1:0] top_nxt;
  logic                  overflow_nxt;
  logic                  underflow_nxt;
  logic                  mem_we;
  logic [IDX_WIDTH-1:0]  mem_idx;
  logic [PTR_WIDTH-1:0]  count_m1;
  logic [PTR_WIDTH-1:0]  count_m2;
  logic [IDX_WIDTH-1:0]  idx_push;
  logic [IDX_WIDTH-1:0]  idx_top;
  logic [IDX_WIDTH-1:0]  idx_below;

  assign empty     = (count == '0);
  assign full      = (count == PTR_WIDTH'(DEPTH));
  assign count_m1  = count - PTR_WIDTH'(1);
  assign count_m2  = count - PTR_WIDTH'(2);
  assign idx_push  = count[IDX_WIDTH-1:0];
  assign idx_top   = count_m1[IDX_WIDTH-1:0];
  assign idx_below = count_m2[IDX_WIDTH-1:0];

  always_comb begin
    count_nxt     = count;
    top_nxt       = top_addr;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    mem_we        = 1'b0;
    mem_idx       = idx_push;
    if (clear) begin
      count_nxt     = '0;
      top_nxt       = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else if (!stall) begin
      if (push_stack && pop_stack && !empty) begin
        // RET+JSB together: overwrite the top entry, depth unchanged
        mem_we  = 1'b1;
        mem_idx = idx_top;
        top_nxt = push_addr;
      end else if (push_stack) begin
        if (full) begin
          overflow_nxt = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_idx   = idx_push;
          count_nxt = count + PTR_WIDTH'(1);
          top_nxt   = push_addr;
        end
      end else if (pop_stack) begin
        if (empty) begin
          underflow_nxt = 1'b1;
        end else if (count == PTR_WIDTH'(1)) begin
          count_nxt = '0;
          top_nxt   = '0;
        end else begin
          count_nxt = count_m1;
          top_nxt   = mem[idx_below];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      top_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      top_addr  <= top_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // Storage needs no reset: entries above count are never observed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= push_addr;
    end
  end

endmodule

// File: tb/tb_return_stack_controller.sv
// Self-checking bench for return_stack_controller: directed vector table, hand
// sequences for overflow and async reset, and random traffic against a queue model.
module tb_return_stack_controller;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_stack = 1'b0;
  logic          pop_stack = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic          stall = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] top_addr;
  logic [PW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] model_q [$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  return_stack_controller #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .push_stack(push_stack), .pop_stack(pop_stack),
    .push_addr(push_addr), .stall(stall), .clear(clear), .top_addr(top_addr),
    .count(count), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic          pop;
    logic          stl;
    logic          clr;
    logic [AW-1:0] addr;
    logic [AW-1:0] e_top;
    logic [PW-1:0] e_cnt;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic p, input logic po, input logic st, input logic cl,
                            input logic [AW-1:0] a);
    if (cl) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!st) begin
      if (p && po && model_q.size() > 0) model_q[model_q.size()-1] = a;
      else if (p) begin
        if (model_q.size() == DEPTH) m_ovf = 1'b1;
        else model_q.push_back(a);
      end else if (po) begin
        if (model_q.size() == 0) m_unf = 1'b1;
        else void'(model_q.pop_back());
      end
    end
  endtask

  function automatic logic [AW-1:0] model_top();
    return (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
  endfunction

  task automatic drive(input logic p, input logic po, input logic st, input logic cl,
                       input logic [AW-1:0] a);
    push_stack = p;
    pop_stack  = po;
    stall      = st;
    clear      = cl;
    push_addr  = a;
    @(posedge clk);
    model_step(p, po, st, cl, a);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_top"},   int'(top_addr),  int'(model_top()));
    chk({tag, "_count"}, int'(count),     model_q.size());
    chk({tag, "_empty"}, int'(empty),     int'(model_q.size() == 0));
    chk({tag, "_full"},  int'(full),      int'(model_q.size() == DEPTH));
    chk({tag, "_ovf"},   int'(overflow),  int'(m_ovf));
    chk({tag, "_unf"},   int'(underflow), int'(m_unf));
  endtask

  function automatic vec_t mk(input logic p, input logic po, input logic st, input logic cl,
                              input int a, input int t, input int c, input logic o, input logic u);
    vec_t v;
    v.push = p; v.pop = po; v.stl = st; v.clr = cl; v.addr = AW'(a);
    v.e_top = AW'(t); v.e_cnt = PW'(c); v.e_ovf = o; v.e_unf = u;
    return v;
  endfunction

  initial begin
    // push, pop, stall, clear, addr, exp top, exp count, exp ovf, exp unf
    tbl.push_back(mk(1, 0, 0, 0, 'h010, 'h010, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 'h020, 'h020, 2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 'h030, 'h030, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h000, 'h020, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h000, 'h010, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h000, 'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h000, 'h000, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 'h055, 'h055, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 'h000, 'h000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 'h0A0, 'h0A0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 'h0B0, 'h0B0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h000, 'h000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 'h011, 'h011, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 'h022, 'h011, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 'h000, 'h011, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h000, 'h000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 'h077, 'h077, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 'h099, 'h000, 0, 0, 0));

    #12;
    chk("rst_top",   int'(top_addr),  0);
    chk("rst_count", int'(count),     0);
    chk("rst_empty", int'(empty),     1);
    chk("rst_full",  int'(full),      0);
    chk("rst_ovf",   int'(overflow),  0);
    chk("rst_unf",   int'(underflow), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].push, tbl[i].pop, tbl[i].stl, tbl[i].clr, tbl[i].addr);
      chk($sformatf("vec%0d_top", i),   int'(top_addr),  int'(tbl[i].e_top));
      chk($sformatf("vec%0d_count", i), int'(count),     int'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_empty", i), int'(empty),     int'(tbl[i].e_cnt == 0));
      chk($sformatf("vec%0d_ovf", i),   int'(overflow),  int'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_unf", i),   int'(underflow), int'(tbl[i].e_unf));
    end

    // Overflow: nine pushes into an eight-deep stack, then drain.
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0, AW'(12'h100 + i));
      if (i == 7) begin
        chk("ovf_full8", int'(full), 1);
        chk("ovf_flag8", int'(overflow), 0);
      end
    end
    chk("ovf_flag9", int'(overflow), 1);
    chk("ovf_top9",  int'(top_addr), 'h107);
    chk("ovf_cnt9",  int'(count), DEPTH);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_top", k), int'(top_addr), 'h107 - k);
      drive(0, 1, 0, 0, '0);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_top",   int'(top_addr), 0);
    chk("drain_unf",   int'(underflow), 0);
    chk("drain_ovf",   int'(overflow), 1);
    drive(0, 0, 0, 1, '0);

    // Async reset mid-cycle with four entries.
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, AW'(12'h200 + i));
    chk("pre_rst_count", int'(count), 4);
    drive(0, 0, 0, 0, '0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_top",   int'(top_addr), 0);
    chk("arst_empty", int'(empty), 1);
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 0, 12'h3C5);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_top",   int'(top_addr), 'h3C5);

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic p, po, st, cl;
      p  = ($urandom_range(99, 0) < 55);
      po = ($urandom_range(99, 0) < 40);
      st = ($urandom_range(99, 0) < 10);
      cl = ($urandom_range(199, 0) < 3);
      drive(p, po, st, cl, AW'($urandom));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
